// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM port arbiter and the display-side blocks
// that share its default widths.
package vram_arbiter_pkg;

  localparam int VRAM_ADDR_WIDTH = 16;
  localparam int VRAM_DATA_WIDTH = 16;

  typedef enum logic {
    OWNER_DISP = 1'b0,
    OWNER_HOST = 1'b1
  } owner_t;

endpackage

// File: rtl/vram_return_pipe.sv
// Valid/owner-tag shift register that tracks reads in flight through the
// VRAM macro, so returning data is steered to the requester that issued it.
module vram_return_pipe
  import vram_arbiter_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic   clk,
  input  logic   _reset,
  input  logic   issue_vld,
  input  owner_t issue_tag,
  output logic   ret_vld,
  output owner_t ret_tag
);

  logic [STAGES-1:0] vld_p;
  owner_t            tag_p [STAGES];

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) tag_p[i] <= OWNER_DISP;
    end else begin
      vld_p[0] <= issue_vld;
      tag_p[0] <= issue_tag;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign ret_vld = vld_p[STAGES-1];
  assign ret_tag = tag_p[STAGES-1];

endmodule

// File: rtl/vram_arbiter.sv
// Two-way arbiter for the single VRAM port: display fetch has priority during
// active scan, host owns the port in vblank and is forced through after a bounded wait.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH    = VRAM_DATA_WIDTH,
  parameter int MEM_LATENCY   = 1,
  parameter int MAX_HOST_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  vblank,
  input  logic                  hblank,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_ack,
  output logic                  disp_rdata_valid,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  input  logic                  host_req,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic                  host_rdata_valid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_HOST_WAIT);

  function automatic logic [7:0] wait_next(input logic [7:0] cnt);
    return (cnt >= WAIT_LIMIT) ? WAIT_LIMIT : cnt + 8'd1;
  endfunction

  logic [7:0] wait_cnt;
  logic       disp_pend, host_pend, host_win, disp_win;
  logic       ret_vld;
  owner_t     ret_tag;

  // hblank only matters to the display fetch logic upstream of this block
  logic unused_hblank;
  assign unused_hblank = hblank;

  // A requester whose ack is showing still holds req this cycle; mask it so
  // the same request is not issued twice.
  always_comb begin
    disp_pend = disp_req && !disp_ack;
    host_pend = host_req && !host_ack;
    host_win  = host_pend && (!disp_pend || vblank || (wait_cnt == WAIT_LIMIT));
    disp_win  = disp_pend && !host_win;
  end

  // Issue stage: decision registered onto the memory port and the acks
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      disp_ack  <= 1'b0;
      host_ack  <= 1'b0;
      wait_cnt  <= 8'd0;
    end else begin
      mem_en   <= host_win || disp_win;
      mem_wr   <= host_win && host_wr;
      disp_ack <= disp_win;
      host_ack <= host_win;
      if (host_win) begin
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
      end else if (disp_win) begin
        mem_addr  <= disp_addr;
      end
      if (!host_req || host_win) wait_cnt <= 8'd0;
      else if (host_pend)        wait_cnt <= wait_next(wait_cnt);
    end
  end

  vram_return_pipe #(
    .STAGES(MEM_LATENCY)
  ) u_return_pipe (
    .clk      (clk),
    ._reset   (_reset),
    .issue_vld(mem_en && !mem_wr),
    .issue_tag(host_ack ? OWNER_HOST : OWNER_DISP),
    .ret_vld  (ret_vld),
    .ret_tag  (ret_tag)
  );

  // Return stage: capture mem_rdata for whichever owner's tag just emerged
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      disp_rdata_valid <= 1'b0;
      host_rdata_valid <= 1'b0;
      disp_rdata       <= '0;
      host_rdata       <= '0;
    end else begin
      disp_rdata_valid <= ret_vld && (ret_tag == OWNER_DISP);
      host_rdata_valid <= ret_vld && (ret_tag == OWNER_HOST);
      if (ret_vld && (ret_tag == OWNER_DISP)) disp_rdata <= mem_rdata;
      if (ret_vld && (ret_tag == OWNER_HOST)) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: randomized requesters, a VRAM behavioural model and
// a priority/return-order reference model kept entirely inside the bench.
module tb_vram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 3;
  localparam int MAXW = 8;

  logic          clk = 1'b0;
  logic          _reset;
  logic          vblank, hblank;
  logic          disp_req, host_req, host_wr;
  logic [AW-1:0] disp_addr, host_addr, mem_addr;
  logic [DW-1:0] host_wdata, disp_rdata, host_rdata, mem_wdata, mem_rdata;
  logic          disp_ack, disp_rdata_valid, host_ack, host_rdata_valid, mem_en, mem_wr;

  vram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .MAX_HOST_WAIT(MAXW)
  ) dut (
    .clk(clk), ._reset(_reset), .vblank(vblank), .hblank(hblank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rdata_valid(disp_rdata_valid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata_valid(host_rdata_valid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [7:0] a);
    return 16'hA5A5 ^ {a, a + 8'd77};
  endfunction

  // VRAM macro model: writes land at the strobe edge, reads return LAT cycles later
  logic [DW-1:0] mem [256];
  bit            written [256];
  logic [DW-1:0] rdq [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      mem[mem_addr[7:0]]     <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
    rdq[0] <= (mem_en && !mem_wr) ?
              (written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_word(mem_addr[7:0])) : 16'hDEAD;
    for (int i = 1; i < LAT; i++) rdq[i] <= rdq[i-1];
  end
  assign mem_rdata = rdq[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: which requester is showing an ack, host's lost-cycle count,
  // expected memory contents and the queue of reads awaiting return.
  typedef struct {bit owner; logic [DW-1:0] data; int due;} ret_t;
  ret_t          rq[$];
  logic [DW-1:0] ref_mem [256];
  logic          m_dack, m_hack;
  int            m_wait;
  logic          e_dack, e_hack, e_en, e_wr, e_dvld, e_hvld;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_ddata, e_hdata;

  function automatic bit chance(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic model_clear();
    m_dack = 0; m_hack = 0; m_wait = 0;
    e_dack = 0; e_hack = 0; e_en = 0; e_wr = 0; e_dvld = 0; e_hvld = 0;
    rq.delete();
  endtask

  // Predict this cycle's decision from the current inputs, then clock once.
  task automatic advance();
    bit dp, hp, hw, dw;
    ret_t r;
    dp = disp_req && !m_dack;
    hp = host_req && !m_hack;
    hw = hp && (!dp || vblank || m_wait == MAXW);
    dw = dp && !hw;
    if (hp && dw)               m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
    else if (!host_req || hw)   m_wait = 0;
    e_en    = hw || dw;
    e_wr    = hw && host_wr;
    e_addr  = hw ? host_addr : disp_addr;
    e_wdata = host_wdata;
    if (e_wr) ref_mem[host_addr[7:0]] = host_wdata;
    else if (e_en) begin
      r.owner = hw; r.data = ref_mem[e_addr[7:0]]; r.due = cyc + LAT + 2;
      rq.push_back(r);
    end
    @(posedge clk); #1;
    cyc++;
    m_dack = dw; m_hack = hw; e_dack = dw; e_hack = hw;
    e_dvld = 0; e_hvld = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.owner) begin e_hvld = 1; e_hdata = r.data; end
      else         begin e_dvld = 1; e_ddata = r.data; end
    end
  endtask

  task automatic run_traffic(input string name, input int ncyc, input int p_d, input int p_h,
                             input int p_drop, input int p_wr, input int vb_mode);
    int run = 0, max_run = 0;
    bit host_held;
    for (int c = 0; c < ncyc; c++) begin
      if (e_dack || !disp_req) begin
        disp_req  = chance(p_d);
        disp_addr = AW'($urandom_range(255, 0));
      end else if (chance(p_drop)) disp_req = 0;
      if (e_hack || !host_req) begin
        host_req   = chance(p_h);
        host_wr    = chance(p_wr);
        host_addr  = AW'($urandom_range(255, 0));
        host_wdata = DW'($urandom);
      end else if (chance(p_drop)) host_req = 0;
      vblank    = (vb_mode == 2) ? ((c / 12) % 2 == 1) : (vb_mode == 1);
      hblank    = chance(50);
      host_held = host_req;
      advance();
      if (host_held && !host_ack) run++; else run = 0;
      if (run > max_run) max_run = run;
      n_tests++; if (disp_ack !== e_dack) begin n_fail++;
        $display("FAIL %s cyc %0d disp_ack got %b want %b", name, cyc, disp_ack, e_dack); end
      n_tests++; if (host_ack !== e_hack) begin n_fail++;
        $display("FAIL %s cyc %0d host_ack got %b want %b", name, cyc, host_ack, e_hack); end
      n_tests++; if (mem_en !== e_en) begin n_fail++;
        $display("FAIL %s cyc %0d mem_en got %b want %b", name, cyc, mem_en, e_en); end
      if (e_en) begin
        n_tests++; if (mem_wr !== e_wr || mem_addr !== e_addr) begin n_fail++;
          $display("FAIL %s cyc %0d mem_wr/addr got %b/%h want %b/%h", name, cyc, mem_wr, mem_addr, e_wr, e_addr); end
        if (e_wr) begin
          n_tests++; if (mem_wdata !== e_wdata) begin n_fail++;
            $display("FAIL %s cyc %0d mem_wdata got %h want %h", name, cyc, mem_wdata, e_wdata); end
        end
      end
      n_tests++; if (disp_rdata_valid !== e_dvld || host_rdata_valid !== e_hvld) begin n_fail++;
        $display("FAIL %s cyc %0d rdata_valid disp/host got %b/%b want %b/%b",
                 name, cyc, disp_rdata_valid, host_rdata_valid, e_dvld, e_hvld); end
      if (e_dvld) begin
        n_tests++; if (disp_rdata !== e_ddata) begin n_fail++;
          $display("FAIL %s cyc %0d disp_rdata got %h want %h", name, cyc, disp_rdata, e_ddata); end
      end
      if (e_hvld) begin
        n_tests++; if (host_rdata !== e_hdata) begin n_fail++;
          $display("FAIL %s cyc %0d host_rdata got %h want %h", name, cyc, host_rdata, e_hdata); end
      end
    end
    n_tests++; if (max_run > MAXW + 1) begin n_fail++;
      $display("FAIL %s host_wait longest run %0d want <= %0d", name, max_run, MAXW + 1); end
  endtask

  task automatic test_reset();
    _reset = 1; vblank = 0; hblank = 0; disp_req = 0; host_req = 0; host_wr = 0;
    disp_addr = '0; host_addr = '0; host_wdata = '0;
    #1 _reset = 0;
    #2;
    n_tests++; if ({disp_ack, host_ack, mem_en, mem_wr, disp_rdata_valid, host_rdata_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 000000",
        {disp_ack, host_ack, mem_en, mem_wr, disp_rdata_valid, host_rdata_valid}); end
    n_tests++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_fail++;
      $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_tests++; if (disp_rdata !== '0 || host_rdata !== '0) begin n_fail++;
      $display("FAIL reset_rdata got %h/%h want 0/0", disp_rdata, host_rdata); end
    repeat (2) @(posedge clk);
    #1 _reset = 1;
    model_clear();
    advance();
    n_tests++; if ({disp_ack, host_ack, mem_en} !== 3'b0) begin n_fail++;
      $display("FAIL reset_idle got %b want 000", {disp_ack, host_ack, mem_en}); end
  endtask

  task automatic test_host_only();
    vblank = 1; host_req = 1; host_wr = 1; host_addr = 16'h0010; host_wdata = 16'hBEEF;
    advance();
    n_tests++; if (host_ack !== 1'b1 || disp_ack !== 1'b0) begin n_fail++;
      $display("FAIL host_write_ack got %b/%b want 1/0", host_ack, disp_ack); end
    n_tests++; if ({mem_en, mem_wr} !== 2'b11 || mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL host_write_bus got %b%b %h %h want 11 0010 beef", mem_en, mem_wr, mem_addr, mem_wdata); end
    host_wr = 0;
    advance();
    n_tests++; if (host_ack !== 1'b0 || mem_en !== 1'b0) begin n_fail++;
      $display("FAIL host_masked got ack %b en %b want 0 0", host_ack, mem_en); end
    advance();
    n_tests++; if (host_ack !== 1'b1 || {mem_en, mem_wr} !== 2'b10 || mem_addr !== 16'h0010) begin n_fail++;
      $display("FAIL host_read_issue got %b %b%b %h want 1 10 0010", host_ack, mem_en, mem_wr, mem_addr); end
    host_req = 0;
    for (int k = 1; k <= LAT + 2; k++) begin
      advance();
      n_tests++; if (host_rdata_valid !== (k == LAT + 1) || disp_rdata_valid !== 1'b0) begin n_fail++;
        $display("FAIL host_read_return k=%0d valid host/disp got %b/%b want %b/0",
                 k, host_rdata_valid, disp_rdata_valid, k == LAT + 1); end
      if (k == LAT + 1) begin
        n_tests++; if (host_rdata !== 16'hBEEF) begin n_fail++;
          $display("FAIL host_read_data got %h want beef", host_rdata); end
      end
    end
  endtask

  task automatic test_contention();
    run_traffic("contention", 60, 100, 100, 0, 30, 0);
  endtask

  task automatic test_vblank_host();
    run_traffic("vblank_host", 40, 100, 80, 0, 30, 1);
  endtask

  task automatic test_alternating_reads();
    run_traffic("alt_reads", 60, 70, 70, 0, 0, 2);
  endtask

  task automatic test_withdraw();
    run_traffic("withdraw", 80, 60, 60, 25, 30, 2);
  endtask

  task automatic test_reset_inflight();
    run_traffic("drain", LAT + 4, 0, 0, 0, 0, 1);
    vblank = 1; disp_req = 1; disp_addr = 16'h0021; host_req = 0;
    advance();
    disp_req = 0; host_req = 1; host_wr = 0; host_addr = 16'h0042;
    advance();
    host_req = 0;
    #2 _reset = 0;
    #1;
    n_tests++; if ({disp_ack, host_ack, mem_en, mem_wr, disp_rdata_valid, host_rdata_valid} !== 6'b0
                   || mem_addr !== '0) begin n_fail++;
      $display("FAIL inflight_reset_async got %b addr %h want 000000 addr 0000",
        {disp_ack, host_ack, mem_en, mem_wr, disp_rdata_valid, host_rdata_valid}, mem_addr); end
    repeat (2) @(posedge clk);
    #1 _reset = 1;
    model_clear();
    for (int k = 0; k < LAT + 4; k++) begin
      advance();
      n_tests++; if (disp_rdata_valid !== 1'b0 || host_rdata_valid !== 1'b0) begin n_fail++;
        $display("FAIL inflight_discard k=%0d valid disp/host got %b/%b want 0/0",
                 k, disp_rdata_valid, host_rdata_valid); end
    end
    host_req = 1; host_wr = 0; host_addr = 16'h0042;
    advance();
    n_tests++; if (host_ack !== 1'b1 || mem_en !== 1'b1) begin n_fail++;
      $display("FAIL post_reset_host_ack got ack %b en %b want 1 1", host_ack, mem_en); end
    host_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    model_clear();
    test_reset();
    test_host_only();
    test_contention();
    test_vblank_host();
    test_alternating_reads();
    test_withdraw();
    test_reset_inflight();
    run_traffic("final_drain", LAT + 4, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
